db_sao_band_search: RTL and testbench

DB_SAO_BAND_SEARCH -- requirements
Module: db_sao_band_search

---
 rtl/db_sao_band_search.sv | 137 +++++++++++++
 tb/tb_db_sao_band_search.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/db_sao_band_search.sv
// ---------------------------------------------------------------------------
// db_sao_band_search
//
// Finds the cheapest run of four consecutive SAO bands for one CTB. The 32
// band costs stream in one per accepted cycle. A running sum over the last
// four costs gives every 4-band window cost. The lowest-cost window and its
// start band are kept.
//
// Ports
//   clk           : sole clock, rising edge
//   rst           : asynchronous, active-high reset
//   start_i       : one-cycle pulse that opens a new search (taken in IDLE only)
//   cost_valid_i  : qualifies cost_i; one band cost accepted per asserted cycle
//   cost_i        : signed RD cost of one band, bands in order 0..31
//   busy_o        : high while costs are being accumulated
//   done_o        : one-cycle pulse, results valid from this cycle on
//   b_cost_o      : signed minimum 4-band window cost (DIS_WIDTH+5 bits)
//   b_band_o      : start band (0..28) of the minimum window
// ---------------------------------------------------------------------------
module db_sao_band_search #(
  parameter int DIS_WIDTH = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        cost_valid_i,
  input  logic signed [DIS_WIDTH+2:0] cost_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic signed [DIS_WIDTH+4:0] b_cost_o,
  output logic        [4:0]           b_band_o
);

  localparam int CW = DIS_WIDTH + 3;
  localparam int SW = DIS_WIDTH + 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t               state;
  logic [4:0]           band_cnt;
  logic signed [CW-1:0] win [4];
  logic signed [SW-1:0] sum;

  logic signed [SW-1:0] cost_ext;
  logic signed [SW-1:0] oldest_ext;
  logic signed [SW-1:0] sum_next;
  logic [4:0]           win_band;

  // win[3] is the oldest entry, so it leaves the sum when the new cost enters.
  // The sum of four full-range costs fits in SW bits. Any wrap in the
  // intermediate value cancels out, so saturation is not needed.
  always_comb begin
    cost_ext   = {{(SW-CW){cost_i[CW-1]}}, cost_i};
    oldest_ext = {{(SW-CW){win[3][CW-1]}}, win[3]};
    sum_next   = sum + cost_ext - oldest_ext;
    win_band   = band_cnt - 5'd3;
  end

  // Control, window and result registers in one block.
  // The window is cleared on start, so the first three partial sums come out
  // right without special cases. The window that ends at the band being
  // accepted starts at band_cnt-3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      band_cnt <= '0;
      win[0]   <= '0;
      win[1]   <= '0;
      win[2]   <= '0;
      win[3]   <= '0;
      sum      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      b_cost_o <= '0;
      b_band_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state    <= ACC;
            busy_o   <= 1'b1;
            band_cnt <= '0;
            win[0]   <= '0;
            win[1]   <= '0;
            win[2]   <= '0;
            win[3]   <= '0;
            sum      <= '0;
          end
        end

        ACC: begin
          if (cost_valid_i) begin
            win[0]   <= cost_i;
            win[1]   <= win[0];
            win[2]   <= win[1];
            win[3]   <= win[2];
            sum      <= sum_next;
            band_cnt <= band_cnt + 5'd1;

            // Window 0 always loads. Later windows need a strictly lower
            // cost, so on a tie the lower start band is kept.
            if (band_cnt == 5'd3) begin
              b_cost_o <= sum_next;
              b_band_o <= win_band;
            end else if ((band_cnt > 5'd3) && (sum_next < b_cost_o)) begin
              b_cost_o <= sum_next;
              b_band_o <= win_band;
            end

            if (band_cnt == 5'd31) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end

        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db_sao_band_search.sv
// ---------------------------------------------------------------------------
// tb_db_sao_band_search
//
// Directed bench for db_sao_band_search. Inputs change on the falling edge,
// and outputs are sampled on the falling edge. Every result is compared with
// a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_db_sao_band_search;

  localparam int DIS_WIDTH = 25;
  localparam int CW = DIS_WIDTH + 3;
  localparam int SW = DIS_WIDTH + 5;

  logic                 clk;
  logic                 rst;
  logic                 start_i;
  logic                 cost_valid_i;
  logic signed [CW-1:0] cost_i;
  logic                 busy_o;
  logic                 done_o;
  logic signed [SW-1:0] b_cost_o;
  logic        [4:0]    b_band_o;

  logic signed [CW-1:0] costs [32];
  int numCompared;
  int numMismatched;

  db_sao_band_search #(.DIS_WIDTH(DIS_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .cost_valid_i (cost_valid_i),
    .cost_i       (cost_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .b_cost_o     (b_cost_o),
    .b_band_o     (b_band_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [39:0] observed,
                             input logic signed [39:0] expected);
    numCompared++;
    assert (observed === expected) else begin
      numMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one full search over costs[] and then checks timing and results.
  // withGaps inserts 0-3 idle cycles before each cost. withNoise drives
  // start_i while the search is running, and also drives a cost in the
  // start cycle. That cost must be dropped.
  task automatic applyStimulus(input bit withGaps, input bit withNoise, input string tag,
                               input int expBand, input int expCost);
    bit earlyDone;
    bit busyDropped;
    int gap;
    earlyDone   = 1'b0;
    busyDropped = 1'b0;

    @(negedge clk);
    start_i      = 1'b1;
    cost_valid_i = withNoise;
    cost_i       = withNoise ? -28'sd99999 : '0;
    @(negedge clk);
    start_i      = 1'b0;
    cost_valid_i = 1'b0;
    checkOutput({tag, "_busy_after_start"}, busy_o, 1);

    for (int b = 0; b < 32; b++) begin
      if (withGaps) begin
        gap = int'($urandom_range(0, 3));
        for (int i = 0; i < gap; i++) begin
          start_i      = withNoise && (i == 0);
          cost_valid_i = 1'b0;
          cost_i       = CW'($urandom);
          @(negedge clk);
          if (done_o) earlyDone = 1'b1;
          if (!busy_o) busyDropped = 1'b1;
        end
      end
      start_i      = withNoise && (b == 5 || b == 20);
      cost_valid_i = 1'b1;
      cost_i       = costs[b];
      @(negedge clk);
      if (b < 31) begin
        if (done_o) earlyDone = 1'b1;
        if (!busy_o) busyDropped = 1'b1;
      end
    end
    start_i      = 1'b0;
    cost_valid_i = 1'b0;

    checkOutput({tag, "_no_early_done"}, earlyDone, 0);
    checkOutput({tag, "_busy_held"}, busyDropped, 0);
    checkOutput({tag, "_done_pulse"}, done_o, 1);
    checkOutput({tag, "_band"}, b_band_o, expBand);
    checkOutput({tag, "_cost"}, b_cost_o, expCost);

    // A start in the DONE cycle must be ignored.
    start_i = withNoise;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput({tag, "_done_cleared"}, done_o, 0);
    checkOutput({tag, "_busy_after_done"}, busy_o, 0);
    checkOutput({tag, "_band_held"}, b_band_o, expBand);
    checkOutput({tag, "_cost_held"}, b_cost_o, expCost);
  endtask

  initial begin
    bit sawDone;
    numCompared   = 0;
    numMismatched = 0;
    rst           = 1'b1;
    start_i       = 1'b0;
    cost_valid_i  = 1'b0;
    cost_i        = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_cost", b_cost_o, 0);
    checkOutput("reset_band", b_band_o, 0);
    rst = 1'b0;
    $display("[TB] reset released");

    // Ramp 0..31: window k costs 4k+6, so window 0 wins with cost 6
    for (int b = 0; b < 32; b++) costs[b] = CW'(b);
    applyStimulus(1'b0, 1'b0, "ramp", 0, 6);

    // Dip at bands 10..13
    for (int b = 0; b < 32; b++) costs[b] = (b >= 10 && b <= 13) ? -28'sd50 : 28'sd100;
    applyStimulus(1'b0, 1'b0, "dip10", 10, -200);

    // Dip in the last window, which is evaluated together with band 31
    for (int b = 0; b < 32; b++) costs[b] = (b >= 28) ? -28'sd50 : 28'sd100;
    applyStimulus(1'b0, 1'b0, "dip28", 28, -200);

    // Every window ties at 20, so the lowest band is kept
    for (int b = 0; b < 32; b++) costs[b] = 28'sd5;
    applyStimulus(1'b0, 1'b0, "ties", 0, 20);

    // Same dip as dip10, with random gaps and stray starts
    for (int b = 0; b < 32; b++) costs[b] = (b >= 10 && b <= 13) ? -28'sd50 : 28'sd100;
    applyStimulus(1'b1, 1'b1, "gaps", 10, -200);

    // Abort a search after 17 accepted costs
    for (int b = 0; b < 32; b++) costs[b] = CW'(31 - b);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int b = 0; b < 17; b++) begin
      cost_valid_i = 1'b1;
      cost_i       = costs[b];
      @(negedge clk);
    end
    cost_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_done", done_o, 0);
    checkOutput("abort_cost", b_cost_o, 0);
    checkOutput("abort_band", b_band_o, 0);
    @(negedge clk);
    rst = 1'b0;
    // With no new start, costs are ignored and done must never pulse
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cost_valid_i = 1'b1;
      cost_i       = CW'(i);
      @(negedge clk);
      if (done_o || busy_o) sawDone = 1'b1;
    end
    cost_valid_i = 1'b0;
    checkOutput("abort_stays_idle", sawDone, 0);
    for (int b = 0; b < 32; b++) costs[b] = CW'(b);
    applyStimulus(1'b0, 1'b0, "after_abort", 0, 6);

    // Most negative cost everywhere: 4 x -2^27 = -2^29 fits without overflow
    for (int b = 0; b < 32; b++) costs[b] = {1'b1, {(CW-1){1'b0}}};
    applyStimulus(1'b0, 1'b0, "minval", 0, -536870912);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
